ddr2_local_arbiter: RTL and testbench

Round-robin arbiter that shares the single DDR2 controller local interface (25-bit word address, 32-bit data, 4-bit byte enable, 3-bit burst size) among `NUM_PORTS` requesters. It sits between the user-side masters and the controller/PHY top, on `phy_clk`. It keeps write bursts atomic and tracks outstanding reads in a return FIFO so each read beat goes back to the port that issued it.

---
 rtl/ddr2_arb_pkg.sv | 18 +
 rtl/ddr2_arb_rtn_fifo.sv | 45 ++++
 rtl/ddr2_local_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_ddr2_local_arbiter.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr2_arb_pkg.sv
// Shared types and helpers for the DDR2 local-interface arbiter.
package ddr2_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    WBURST = 1'b1
  } arb_state_e;

  // Port-index width; a single requester still needs one bit to index it.
  function automatic int unsigned port_w(input int unsigned num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

  function automatic int unsigned eff_size(input int unsigned size);
    return (size == 0) ? 1 : size;
  endfunction

endpackage

// File: rtl/ddr2_arb_rtn_fifo.sv
// Return-tag FIFO: one {port, size} entry per outstanding read command.
module ddr2_arb_rtn_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; clearing the pointers and count is the flush.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ddr2_local_arbiter.sv
// Round-robin arbiter sharing one DDR2 controller local interface among several masters,
// with atomic write bursts and a tag FIFO that steers read returns back to their issuer.
module ddr2_local_arbiter
  import ddr2_arb_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32,
  parameter int BE_W      = 4,
  parameter int SIZE_W    = 3,
  parameter int RQ_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS*ADDR_W-1:0] p_address,
  input  logic [NUM_PORTS*DATA_W-1:0] p_wdata,
  input  logic [NUM_PORTS*BE_W-1:0]   p_be,
  input  logic [NUM_PORTS*SIZE_W-1:0] p_size,
  input  logic [NUM_PORTS-1:0]        p_read,
  input  logic [NUM_PORTS-1:0]        p_write,
  output logic [NUM_PORTS-1:0]        p_ready,
  output logic [DATA_W-1:0]           p_rdata,
  output logic [NUM_PORTS-1:0]        p_rdata_valid,
  output logic [ADDR_W-1:0]           local_address,
  output logic [DATA_W-1:0]           local_wdata,
  output logic [BE_W-1:0]             local_be,
  output logic [SIZE_W-1:0]           local_size,
  output logic                        local_read_req,
  output logic                        local_write_req,
  output logic                        local_burstbegin,
  input  logic                        local_ready,
  input  logic                        local_rdata_valid,
  input  logic                        local_init_done,
  input  logic [DATA_W-1:0]           local_rdata,
  output logic                        rtn_err
);
  localparam int PORT_W = port_w(NUM_PORTS);
  localparam int ENT_W  = PORT_W + SIZE_W;
  localparam int CNT_W  = $clog2(RQ_DEPTH) + 1;

  arb_state_e          state, state_n;
  logic [PORT_W-1:0]   rr_ptr, rr_ptr_n, lock, lock_n, win, sel, cand, head_port;
  logic [SIZE_W-1:0]   beats_left, beats_n, win_size, head_size, rtn_cnt;
  logic [NUM_PORTS-1:0] eligible;
  logic                win_valid, win_write, grant, push, pop, last_beat;
  logic                rq_full, rq_empty;
  logic [ENT_W-1:0]    head;
  logic [CNT_W-1:0]    rq_count;

  function automatic logic [PORT_W-1:0] next_port(input logic [PORT_W-1:0] p);
    return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
  endfunction

  // A full return FIFO makes read requests ineligible; writes are unaffected.
  assign eligible = p_write | (p_read & {NUM_PORTS{!rq_full}});

  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = PORT_W'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!win_valid && eligible[cand]) begin
        win_valid = 1'b1;
        win       = cand;
      end
    end
  end

  assign win_write = p_write[win];
  assign win_size  = p_size[win*SIZE_W +: SIZE_W];
  assign grant     = (state == IDLE) && local_init_done && win_valid;
  assign sel       = (state == WBURST) ? lock : win;

  // NOTE: sequential state uses non-blocking assignments only; combinational blocks use blocking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      lock       <= '0;
      beats_left <= '0;
    end else begin
      state      <= state_n;
      rr_ptr     <= rr_ptr_n;
      lock       <= lock_n;
      beats_left <= beats_n;
    end
  end

  // NOTE: every signal gets a default first, so no path through this block can infer a latch.
  always_comb begin
    state_n  = state;
    rr_ptr_n = rr_ptr;
    lock_n   = lock;
    beats_n  = beats_left;
    push     = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant && local_ready) begin
          if (!win_write) begin
            push     = 1'b1;
            rr_ptr_n = next_port(win);
          end else if (eff_size(int'(win_size)) > 1) begin
            lock_n  = win;
            beats_n = SIZE_W'(eff_size(int'(win_size)) - 1);
            state_n = WBURST;
          end else begin
            rr_ptr_n = next_port(win);
          end
        end
      end
      WBURST: begin
        if (p_write[lock] && local_ready) begin
          beats_n = beats_left - 1'b1;
          if (beats_left == SIZE_W'(1)) begin
            rr_ptr_n = next_port(lock);
            state_n  = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Command outputs are a pure mux of the granted port, forced quiet while reset is held.
  always_comb begin
    local_address    = '0;
    local_wdata      = '0;
    local_be         = '0;
    local_size       = '0;
    local_read_req   = 1'b0;
    local_write_req  = 1'b0;
    local_burstbegin = 1'b0;
    p_ready          = '0;
    if (!reset && (state == WBURST || grant)) begin
      local_address = p_address[sel*ADDR_W +: ADDR_W];
      local_wdata   = p_wdata[sel*DATA_W +: DATA_W];
      local_be      = p_be[sel*BE_W +: BE_W];
      local_size    = p_size[sel*SIZE_W +: SIZE_W];
      if (state == WBURST) begin
        local_write_req = p_write[lock];
        p_ready[lock]   = local_ready & p_write[lock];
      end else begin
        local_burstbegin = 1'b1;
        local_write_req  = win_write;
        local_read_req   = !win_write;
        p_ready[win]     = local_ready;
      end
    end
  end

  ddr2_arb_rtn_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RQ_DEPTH)
  ) u_rtn_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({win, win_size}),
    .pop   (pop),
    .rdata (head),
    .count (rq_count),
    .full  (rq_full),
    .empty (rq_empty)
  );

  assign head_port = head[ENT_W-1:SIZE_W];
  assign head_size = head[SIZE_W-1:0];
  // rtn_cnt counts beats already returned for the head command.
  assign last_beat = local_rdata_valid && !rq_empty &&
                     (eff_size(int'(head_size)) == int'(rtn_cnt) + 1);
  assign pop       = last_beat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_rdata       <= '0;
      p_rdata_valid <= '0;
      rtn_cnt       <= '0;
      rtn_err       <= 1'b0;
    end else begin
      p_rdata_valid <= '0;
      if (local_rdata_valid) begin
        if (rq_empty) begin
          rtn_err <= 1'b1;
        end else begin
          p_rdata                  <= local_rdata;
          p_rdata_valid[head_port] <= 1'b1;
          rtn_cnt                  <= last_beat ? '0 : rtn_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr2_local_arbiter.sv
// Self-checking bench: directed scenarios plus randomized read traffic against a queue-based model.
module tb_ddr2_local_arbiter;
  localparam int NP = 2, AW = 25, DW = 32, BW = 4, SW = 3, DEPTH = 16;

  logic              clk, reset;
  logic [NP*AW-1:0]  p_address;
  logic [NP*DW-1:0]  p_wdata;
  logic [NP*BW-1:0]  p_be;
  logic [NP*SW-1:0]  p_size;
  logic [NP-1:0]     p_read, p_write, p_ready, p_rdata_valid;
  logic [DW-1:0]     p_rdata, local_wdata, local_rdata;
  logic [AW-1:0]     local_address;
  logic [BW-1:0]     local_be;
  logic [SW-1:0]     local_size;
  logic              local_read_req, local_write_req, local_burstbegin;
  logic              local_ready, local_rdata_valid, local_init_done, rtn_err;

  int checks = 0, failures = 0;

  // Reference model state
  typedef struct { int port; bit last; } beat_t;
  beat_t          beat_q[$];
  int             grant_log[$];
  int             m_ptr, m_out;
  bit             act [NP];
  logic [AW-1:0]  a_addr [NP];
  logic [SW-1:0]  a_size [NP];
  bit             prev_valid;
  int             prev_port;
  logic [DW-1:0]  prev_data;

  ddr2_local_arbiter #(
    .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .BE_W(BW), .SIZE_W(SW), .RQ_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .p_address(p_address), .p_wdata(p_wdata), .p_be(p_be), .p_size(p_size),
    .p_read(p_read), .p_write(p_write), .p_ready(p_ready),
    .p_rdata(p_rdata), .p_rdata_valid(p_rdata_valid),
    .local_address(local_address), .local_wdata(local_wdata), .local_be(local_be),
    .local_size(local_size), .local_read_req(local_read_req),
    .local_write_req(local_write_req), .local_burstbegin(local_burstbegin),
    .local_ready(local_ready), .local_rdata_valid(local_rdata_valid),
    .local_init_done(local_init_done), .local_rdata(local_rdata), .rtn_err(rtn_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_port(input int p, input bit rd, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [SW-1:0] s);
    p_read[p]              = rd;
    p_write[p]             = wr;
    p_address[p*AW +: AW]  = a;
    p_wdata[p*DW +: DW]    = d;
    p_be[p*BW +: BW]       = '1;
    p_size[p*SW +: SW]     = s;
  endtask

  task automatic clear_inputs();
    p_address = '0; p_wdata = '0; p_be = '0; p_size = '0;
    p_read = '0; p_write = '0;
    local_ready = 1'b0; local_rdata_valid = 1'b0; local_rdata = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    local_init_done = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    m_ptr = 0; m_out = 0; beat_q.delete(); grant_log.delete();
    for (int p = 0; p < NP; p++) act[p] = 1'b0;
    prev_valid = 1'b0;
  endtask

  // One cycle per iteration: drive after the rising edge, compare at the falling edge.
  task automatic run_reads(input int ncyc, input int req_pct, input int rdy_pct, input int ret_pct);
    int win;
    int eff;
    bit beat_now;
    beat_t cur;
    logic [NP-1:0] exp_v;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (!act[p] && $urandom_range(99) < req_pct) begin
          act[p]    = 1'b1;
          a_addr[p] = AW'($urandom);
          a_size[p] = SW'($urandom_range(3));
        end
        set_port(p, act[p], 1'b0, a_addr[p], $urandom, a_size[p]);
      end
      local_ready = ($urandom_range(99) < rdy_pct);
      beat_now = 1'b0;
      cur = '{port: 0, last: 1'b0};
      if (beat_q.size() > 0 && $urandom_range(99) < ret_pct) begin
        beat_now = 1'b1;
        cur = beat_q.pop_front();
        local_rdata_valid = 1'b1;
        local_rdata = $urandom;
      end else begin
        local_rdata_valid = 1'b0;
      end
      @(negedge clk);
      win = -1;
      if (m_out < DEPTH)
        for (int k = 0; k < NP; k++)
          if (win < 0 && act[(m_ptr + k) % NP]) win = (m_ptr + k) % NP;
      checks++;
      if (local_read_req !== (win >= 0)) begin
        failures++; $display("FAIL rd_req cyc=%0d got=%0b exp=%0b", c, local_read_req, win >= 0);
      end
      checks++;
      if (local_write_req !== 1'b0) begin
        failures++; $display("FAIL rd_wr_req cyc=%0d got=%0b exp=0", c, local_write_req);
      end
      if (win >= 0) begin
        checks++;
        if (local_address !== a_addr[win] || local_burstbegin !== 1'b1) begin
          failures++;
          $display("FAIL rd_cmd cyc=%0d addr=%h exp=%h bb=%0b exp=1", c, local_address, a_addr[win], local_burstbegin);
        end
      end
      exp_v = '0;
      if (win >= 0 && local_ready) exp_v[win] = 1'b1;
      checks++;
      if (p_ready !== exp_v) begin
        failures++; $display("FAIL rd_p_ready cyc=%0d got=%b exp=%b", c, p_ready, exp_v);
      end
      exp_v = '0;
      if (prev_valid) exp_v[prev_port] = 1'b1;
      checks++;
      if (p_rdata_valid !== exp_v || (prev_valid && p_rdata !== prev_data)) begin
        failures++;
        $display("FAIL rtn_route cyc=%0d valid=%b exp=%b data=%h exp=%h", c, p_rdata_valid, exp_v, p_rdata, prev_data);
      end
      if (win >= 0 && local_ready) begin
        grant_log.push_back(win);
        eff = (a_size[win] == 0) ? 1 : int'(a_size[win]);
        for (int b = 0; b < eff; b++) beat_q.push_back('{port: win, last: (b == eff - 1)});
        m_out++;
        m_ptr = (win + 1) % NP;
        act[win] = 1'b0;
      end
      if (beat_now && cur.last) m_out--;
      prev_valid = beat_now;
      prev_port  = cur.port;
      prev_data  = local_rdata;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    local_init_done = 1'b1;
    reset = 1'b1;
    set_port(0, 1'b1, 1'b0, 25'h1234, 32'h0, 3'd1);
    set_port(1, 1'b1, 1'b0, 25'h5678, 32'h0, 3'd1);
    local_ready = 1'b1;
    #1;
    checks++;
    if (local_read_req !== 1'b0 || p_ready !== '0 || local_address !== '0 || local_burstbegin !== 1'b0) begin
      failures++; $display("FAIL rst_outputs rd=%0b rdy=%b addr=%h bb=%0b exp=all 0", local_read_req, p_ready, local_address, local_burstbegin);
    end
    @(posedge clk); #1;
    @(negedge clk);
    reset = 1'b0;
    local_init_done = 1'b0;
    #1;
    checks++;
    if (local_read_req !== 1'b0 || p_ready !== '0) begin
      failures++; $display("FAIL init_block rd=%0b rdy=%b exp=0/00", local_read_req, p_ready);
    end
    checks++;
    if (p_rdata_valid !== '0 || p_rdata !== '0 || rtn_err !== 1'b0) begin
      failures++; $display("FAIL rst_rtn valid=%b data=%h err=%0b exp=0", p_rdata_valid, p_rdata, rtn_err);
    end
    local_init_done = 1'b1;
    #1;
    checks++;
    if (local_read_req !== 1'b1 || local_address !== 25'h1234 || p_ready !== 2'b01) begin
      failures++; $display("FAIL first_grant rd=%0b addr=%h rdy=%b exp=1/1234/01", local_read_req, local_address, p_ready);
    end
    clear_inputs();
  endtask

  task automatic test_alternating_reads();
    reset_dut();
    run_reads(12, 100, 100, 100);
    for (int i = 0; i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] !== (i % 2)) begin
        failures++; $display("FAIL alt_order idx=%0d got=%0d exp=%0d", i, grant_log[i], i % 2);
      end
    end
    run_reads(20, 0, 100, 100);
  endtask

  task automatic test_random_reads();
    reset_dut();
    run_reads(300, 40, 70, 50);
    run_reads(100, 0, 100, 100);
    checks++;
    if (rtn_err !== 1'b0) begin
      failures++; $display("FAIL rand_rtn_err got=%0b exp=0", rtn_err);
    end
  endtask

  task automatic test_write_burst();
    reset_dut();
    local_ready = 1'b1;
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b1, 25'h0AA00, 32'hD000_0000, 3'd4);
    set_port(1, 1'b1, 1'b0, 25'h0BB00, 32'h0, 3'd1);
    @(negedge clk);
    checks++;
    if (local_write_req !== 1'b1 || local_burstbegin !== 1'b1 || local_address !== 25'h0AA00 ||
        local_wdata !== 32'hD000_0000 || p_ready !== 2'b01 || local_read_req !== 1'b0) begin
      failures++; $display("FAIL wb_beat1 wr=%0b bb=%0b addr=%h data=%h rdy=%b", local_write_req, local_burstbegin, local_address, local_wdata, p_ready);
    end
    for (int b = 1; b < 4; b++) begin
      @(posedge clk); #1;
      p_wdata[DW-1:0] = 32'hD000_0000 + DW'(b);
      if (b == 1) begin
        local_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (local_write_req !== 1'b1 || local_burstbegin !== 1'b0 || p_ready !== 2'b00) begin
          failures++; $display("FAIL wb_stall wr=%0b bb=%0b rdy=%b exp=1/0/00", local_write_req, local_burstbegin, p_ready);
        end
        @(posedge clk); #1;
        local_ready = 1'b1;
      end
      @(negedge clk);
      checks++;
      if (local_write_req !== 1'b1 || local_burstbegin !== 1'b0 || local_wdata !== 32'hD000_0000 + DW'(b) ||
          p_ready !== 2'b01 || local_read_req !== 1'b0) begin
        failures++; $display("FAIL wb_beat%0d wr=%0b bb=%0b data=%h rdy=%b rd=%0b", b + 1, local_write_req, local_burstbegin, local_wdata, p_ready, local_read_req);
      end
    end
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    checks++;
    if (local_read_req !== 1'b1 || local_address !== 25'h0BB00 || p_ready !== 2'b10 || local_burstbegin !== 1'b1) begin
      failures++; $display("FAIL wb_after rd=%0b addr=%h rdy=%b bb=%0b exp=1/0BB00/10/1", local_read_req, local_address, p_ready, local_burstbegin);
    end
    clear_inputs();
  endtask

  task automatic test_fifo_full();
    reset_dut();
    local_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      set_port(0, 1'b1, 1'b0, AW'(i), '0, 3'd1);
      @(negedge clk);
      checks++;
      if (local_read_req !== 1'b1 || p_ready !== 2'b01) begin
        failures++; $display("FAIL fill_grant idx=%0d rd=%0b rdy=%b exp=1/01", i, local_read_req, p_ready);
      end
    end
    @(posedge clk); #1;
    set_port(0, 1'b1, 1'b0, 25'h100, '0, 3'd1);
    set_port(1, 1'b1, 1'b0, 25'h200, '0, 3'd1);
    @(negedge clk);
    checks++;
    if (local_read_req !== 1'b0 || p_ready !== 2'b00) begin
      failures++; $display("FAIL full_block rd=%0b rdy=%b exp=0/00", local_read_req, p_ready);
    end
    @(posedge clk); #1;
    local_rdata_valid = 1'b1;
    local_rdata = 32'hCAFE_0001;
    @(negedge clk);
    checks++;
    if (local_read_req !== 1'b0) begin
      failures++; $display("FAIL full_prepop rd=%0b exp=0", local_read_req);
    end
    @(posedge clk); #1;
    local_rdata_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (local_read_req !== 1'b1 || local_address !== 25'h200 || p_ready !== 2'b10) begin
      failures++; $display("FAIL full_regrant rd=%0b addr=%h rdy=%b exp=1/200/10", local_read_req, local_address, p_ready);
    end
    checks++;
    if (p_rdata_valid !== 2'b01 || p_rdata !== 32'hCAFE_0001) begin
      failures++; $display("FAIL full_rtn valid=%b data=%h exp=01/cafe0001", p_rdata_valid, p_rdata);
    end
    clear_inputs();
  endtask

  task automatic test_size_zero_and_rtn_err();
    reset_dut();
    local_ready = 1'b1;
    @(posedge clk); #1;
    set_port(1, 1'b1, 1'b0, 25'h0C0, '0, 3'd0);
    @(negedge clk);
    checks++;
    if (local_read_req !== 1'b1 || p_ready !== 2'b10) begin
      failures++; $display("FAIL sz0_grant rd=%0b rdy=%b exp=1/10", local_read_req, p_ready);
    end
    @(posedge clk); #1;
    clear_inputs();
    local_rdata_valid = 1'b1;
    local_rdata = 32'h5EED_0000;
    @(negedge clk);
    @(posedge clk); #1;
    local_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++;
    if (p_rdata_valid !== 2'b10 || p_rdata !== 32'h5EED_0000 || rtn_err !== 1'b0) begin
      failures++; $display("FAIL sz0_rtn valid=%b data=%h err=%0b exp=10/5eed0000/0", p_rdata_valid, p_rdata, rtn_err);
    end
    @(posedge clk); #1;
    local_rdata_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (p_rdata_valid !== 2'b00 || rtn_err !== 1'b1) begin
      failures++; $display("FAIL empty_drop valid=%b err=%0b exp=00/1", p_rdata_valid, rtn_err);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rtn_err !== 1'b1) begin
      failures++; $display("FAIL err_sticky got=%0b exp=1", rtn_err);
    end
  endtask

  task automatic test_reset_mid_burst();
    reset_dut();
    local_ready = 1'b1;
    @(posedge clk); #1;
    set_port(0, 1'b0, 1'b1, 25'h0D00, 32'h1111_0000, 3'd4);
    set_port(1, 1'b1, 1'b0, 25'h0E00, '0, 3'd1);
    @(negedge clk);
    @(posedge clk); #1;
    p_wdata[DW-1:0] = 32'h1111_0001;
    @(negedge clk);
    checks++;
    if (local_write_req !== 1'b1 || local_burstbegin !== 1'b0) begin
      failures++; $display("FAIL rmb_beat2 wr=%0b bb=%0b exp=1/0", local_write_req, local_burstbegin);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (local_write_req !== 1'b0 || local_read_req !== 1'b0 || p_ready !== 2'b00 ||
        local_address !== '0 || local_wdata !== '0 || local_burstbegin !== 1'b0) begin
      failures++; $display("FAIL rmb_quiet wr=%0b rd=%0b rdy=%b addr=%h data=%h exp=all 0", local_write_req, local_read_req, p_ready, local_address, local_wdata);
    end
    clear_inputs();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    local_rdata_valid = 1'b1;
    local_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    @(posedge clk); #1;
    local_rdata_valid = 1'b0;
    local_ready = 1'b1;
    set_port(0, 1'b1, 1'b0, 25'h0F00, '0, 3'd1);
    set_port(1, 1'b1, 1'b0, 25'h0F11, '0, 3'd1);
    @(negedge clk);
    checks++;
    if (rtn_err !== 1'b1 || p_rdata_valid !== 2'b00) begin
      failures++; $display("FAIL late_rtn err=%0b valid=%b exp=1/00", rtn_err, p_rdata_valid);
    end
    checks++;
    if (local_read_req !== 1'b1 || local_address !== 25'h0F00 || p_ready !== 2'b01) begin
      failures++; $display("FAIL rmb_ptr rd=%0b addr=%h rdy=%b exp=1/0F00/01", local_read_req, local_address, p_ready);
    end
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    local_init_done = 1'b0;
    clear_inputs();
    test_reset();
    test_alternating_reads();
    test_random_reads();
    test_write_burst();
    test_fifo_full();
    test_size_zero_and_rtn_err();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
